// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM states, response record.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

   // ALU opcodes; every other 4-bit value is illegal
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_INC = 4'h3;
   localparam logic [3:0] OP_DEC = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
   localparam logic [3:0] OP_SHL = 4'h9;
   localparam logic [3:0] OP_NOT = 4'hA;
   localparam logic [3:0] OP_NEG = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       zero;
      logic       carry;
      logic       err;
   } rsp_t;

endpackage

// File: rtl/alu.sv
// Purpose: 8-bit combinational ALU producing result, zero, carry and illegal-op flags.
// Latency: combinational, no state.
// Backpressure: none; output follows operands/opcode directly.
// Ports: a, b (operands), op (opcode) -> data, zero, carry, err.
module alu
   import alu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] op,
   output logic [7:0] data,
   output logic       zero,
   output logic       carry,
   output logic       err
);

   // Bit 8 is carry for arithmetic (borrow for sub/dec) and a[7] for shl;
   // logic ops leave it clear. Illegal opcodes leave the whole word at 0.
   logic [8:0] sum;
   logic       err_c;

   always_comb begin
      sum   = 9'd0;
      err_c = 1'b0;
      case (op)
         OP_ADD:  sum = {1'b0, a} + {1'b0, b};
         OP_SUB:  sum = {1'b0, a} - {1'b0, b};
         OP_INC:  sum = {1'b0, a} + 9'd1;
         OP_DEC:  sum = {1'b0, a} - 9'd1;
         OP_OR:   sum = {1'b0, a | b};
         OP_AND:  sum = {1'b0, a & b};
         OP_XOR:  sum = {1'b0, a ^ b};
         OP_SHR:  sum = {2'b00, a[7:1]};
         OP_SHL:  sum = {a, 1'b0};
         OP_NOT:  sum = {1'b0, ~a};
         OP_NEG:  sum = {1'b0, ~a} + 9'd1;
         default: err_c = 1'b1;
      endcase
   end

   assign data  = sum[7:0];
   assign carry = sum[8];
   assign zero  = (sum[7:0] == 8'h00);
   assign err   = err_c;

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: two-requester arbiter (round-robin or fixed priority) in front of one shared ALU.
// Latency: accept at edge N -> rsp_valid high for the cycle after edge N+2; 1 op per 3 cycles.
// Backpressure: reqN_ready only in IDLE for the granted, valid requester; no response-side stall.
// Ports: clk, rst_n; req0/req1 {valid, ready, a, b, op}; rsp {valid, id, data, zero, carry, err}; busy.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int RR_EN = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [3:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [3:0] req1_op,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic       rsp_zero,
   output logic       rsp_carry,
   output logic       rsp_err,
   output logic       busy
);

   state_t     state;
   logic       last_id;   // requester served most recently
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [3:0] op_q;
   logic       id_q;
   rsp_t       res_q;

   logic       grant_id;
   logic       accept;
   logic [7:0] alu_data;
   logic       alu_zero;
   logic       alu_carry;
   logic       alu_err;

   // With both requesting, round-robin picks whoever was not served last;
   // fixed priority always favours requester 0.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid)
         grant_id = (RR_EN != 0) ? ~last_id : 1'b0;
      else if (req1_valid)
         grant_id = 1'b1;
   end

   // rst_n gates ready so nothing is offered while reset is held.
   assign req0_ready = rst_n && (state == ST_IDLE) && req0_valid && !grant_id;
   assign req1_ready = rst_n && (state == ST_IDLE) && req1_valid &&  grant_id;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign busy       = (state != ST_IDLE);

   alu u_alu (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .data  (alu_data),
      .zero  (alu_zero),
      .carry (alu_carry),
      .err   (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         last_id   <= 1'b1;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         op_q      <= 4'h0;
         id_q      <= 1'b0;
         res_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= 8'h00;
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= grant_id ? req1_a  : req0_a;
                  b_q     <= grant_id ? req1_b  : req0_b;
                  op_q    <= grant_id ? req1_op : req0_op;
                  id_q    <= grant_id;
                  last_id <= grant_id;
                  state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_q.data  <= alu_data;
               res_q.zero  <= alu_zero;
               res_q.carry <= alu_carry;
               res_q.err   <= alu_err;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               // Response fields change only here, so they hold between pulses.
               rsp_valid <= 1'b1;
               rsp_id    <= id_q;
               rsp_data  <= res_q.data;
               rsp_zero  <= res_q.zero;
               rsp_carry <= res_q.carry;
               rsp_err   <= res_q.err;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter, round-robin and fixed-priority instances side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] req0_op, req1_op;

   logic       rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id;
   logic       rr_rsp_zero, rr_rsp_carry, rr_rsp_err, rr_busy;
   logic [7:0] rr_rsp_data;
   logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
   logic       fp_rsp_zero, fp_rsp_carry, fp_rsp_err, fp_busy;
   logic [7:0] fp_rsp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.RR_EN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rr_rsp_valid), .rsp_id(rr_rsp_id), .rsp_data(rr_rsp_data), .rsp_zero(rr_rsp_zero),
      .rsp_carry(rr_rsp_carry), .rsp_err(rr_rsp_err), .busy(rr_busy)
   );

   alu_arbiter #(.RR_EN(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero),
      .rsp_carry(fp_rsp_carry), .rsp_err(fp_rsp_err), .busy(fp_busy)
   );

   // Reference ALU from plain integer arithmetic: returns {err, zero, carry, data}.
   function automatic logic [10:0] ref_alu(input int a, input int b, input int op);
      int r;
      int d;
      logic c;
      logic e;
      logic [7:0] d8;
      e = 1'b0;
      case (op)
         1:  r = a + b;
         2:  r = a - b;
         3:  r = a + 1;
         4:  r = a - 1;
         5:  r = a | b;
         6:  r = a & b;
         7:  r = a ^ b;
         8:  r = a / 2;
         9:  r = a * 2;
         10: r = 255 - a;
         11: r = 256 - a;
         default: begin r = 0; e = 1'b1; end
      endcase
      if (r < 0) begin
         c = 1'b1;
         d = r + 256;
      end else begin
         c = (r > 255);
         d = r % 256;
      end
      d8 = d[7:0];
      return {e, (d == 0), c, d8};
   endfunction

   task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
   endtask

   // Presents one request for a single clock edge; returns at the negedge after acceptance.
   task automatic issue(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1);
      @(negedge clk);
      drive(v0, a0, b0, op0, v1, a1, b1, op1);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rr_busy || fp_busy) && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rr_busy !== 1'b0 || fp_busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy rr=%0b fp=%0b after %0d cycles, required 0", rr_busy, fp_busy, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 8'h12, 8'h34, 4'h1, 1'b1, 8'h56, 8'h78, 4'h2);
      @(negedge clk);
      checks++;
      if ({rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero,
           rr_rsp_carry, rr_rsp_err, rr_busy} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rr: outputs=%h, required 0000", {rr_req0_ready, rr_req1_ready, rr_rsp_valid,
                  rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err, rr_busy});
      end
      checks++;
      if ({fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_data, fp_rsp_zero,
           fp_rsp_carry, fp_rsp_err, fp_busy} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_fp: outputs=%h, required 0000", {fp_req0_ready, fp_req1_ready, fp_rsp_valid,
                  fp_rsp_id, fp_rsp_data, fp_rsp_zero, fp_rsp_carry, fp_rsp_err, fp_busy});
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b1010) begin
         errors++;
         $display("FAIL first_grant: ready rr0,rr1,fp0,fp1=%b, required 1010",
                  {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (rr_busy !== 1'b1 || fp_busy !== 1'b1) begin
         errors++;
         $display("FAIL first_accept: busy rr=%0b fp=%0b, required 1", rr_busy, fp_busy);
      end
   endtask

   task automatic test_add();
      wait_idle();
      issue(1'b1, 8'hF0, 8'h20, 4'h1, 1'b0, 8'h00, 8'h00, 4'h0);
      checks++;
      if (rr_rsp_valid !== 1'b0 || rr_busy !== 1'b1) begin
         errors++;
         $display("FAIL add_exec: rsp_valid=%0b busy=%0b, required 0 1", rr_rsp_valid, rr_busy);
      end
      @(negedge clk);
      checks++;
      if (rr_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_resp_early: rsp_valid=%0b, required 0", rr_rsp_valid);
      end
      @(negedge clk);
      checks++;
      if ({rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err} !== {1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_rsp: vld=%0b id=%0b data=%h z=%0b c=%0b e=%0b, required 1 0 10 0 1 0",
                  rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err);
      end
      @(negedge clk);
      checks++;
      if (rr_rsp_valid !== 1'b0 || rr_rsp_data !== 8'h10 || rr_rsp_carry !== 1'b1) begin
         errors++;
         $display("FAIL add_hold: vld=%0b data=%h c=%0b, required 0 10 1", rr_rsp_valid, rr_rsp_data, rr_rsp_carry);
      end
   endtask

   task automatic test_arbitration();
      int n;
      logic       exp_id;
      logic [7:0] exp_rr;
      wait_idle();
      apply_reset();
      drive(1'b1, 8'h01, 8'h00, 4'h3, 1'b1, 8'h10, 8'h00, 4'h3);
      for (int k = 0; k < 4; k++) begin
         n = 1;
         @(negedge clk);
         while (!rr_rsp_valid && n < 6) begin
            @(negedge clk);
            n++;
         end
         exp_id = (k % 2 == 1);
         exp_rr = exp_id ? 8'h11 : 8'h02;
         checks++;
         if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== exp_id || rr_rsp_data !== exp_rr) begin
            errors++;
            $display("FAIL rr_grant[%0d]: vld=%0b id=%0b data=%h, required 1 %0b %h",
                     k, rr_rsp_valid, rr_rsp_id, rr_rsp_data, exp_id, exp_rr);
         end
         checks++;
         if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b0 || fp_rsp_data !== 8'h02) begin
            errors++;
            $display("FAIL fp_grant[%0d]: vld=%0b id=%0b data=%h, required 1 0 02",
                     k, fp_rsp_valid, fp_rsp_id, fp_rsp_data);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
   endtask

   task automatic test_dec_neg();
      wait_idle();
      issue(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 8'h55, 4'h4);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err} !== {1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL dec_zero: vld=%0b id=%0b data=%h z=%0b c=%0b e=%0b, required 1 1 ff 0 1 0",
                  rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err);
      end
      wait_idle();
      issue(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 8'h55, 4'hB);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({fp_rsp_valid, fp_rsp_id, fp_rsp_data, fp_rsp_zero, fp_rsp_carry, fp_rsp_err} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL neg_zero: vld=%0b id=%0b data=%h z=%0b c=%0b e=%0b, required 1 1 00 1 1 0",
                  fp_rsp_valid, fp_rsp_id, fp_rsp_data, fp_rsp_zero, fp_rsp_carry, fp_rsp_err);
      end
   endtask

   task automatic test_illegal();
      wait_idle();
      issue(1'b1, 8'h5A, 8'h3C, 4'hE, 1'b0, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rr_rsp_valid, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err, rr_busy} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL illegal_op: vld=%0b data=%h z=%0b c=%0b e=%0b busy=%0b, required 1 00 1 0 1 0",
                  rr_rsp_valid, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err, rr_busy);
      end
   endtask

   task automatic test_reset_mid();
      wait_idle();
      issue(1'b1, 8'h77, 8'h11, 4'h2, 1'b0, 8'h00, 8'h00, 4'h0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero,
           rr_rsp_carry, rr_rsp_err, rr_busy} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid_clear: outputs=%h, required 0000", {rr_req0_ready, rr_req1_ready, rr_rsp_valid,
                  rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err, rr_busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (rr_rsp_valid !== 1'b0 || fp_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_silent[%0d]: rsp_valid rr=%0b fp=%0b, required 0", k, rr_rsp_valid, fp_rsp_valid);
         end
      end
      issue(1'b1, 8'h77, 8'h11, 4'h2, 1'b0, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry} !== {1'b1, 1'b0, 8'h66, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_next: vld=%0b id=%0b data=%h z=%0b c=%0b, required 1 0 66 0 0",
                  rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_zero, rr_rsp_carry);
      end
   endtask

   task automatic test_latch();
      wait_idle();
      issue(1'b1, 8'h05, 8'h03, 4'h1, 1'b0, 8'h00, 8'h00, 4'h0);
      req0_a  = 8'hFF;
      req0_b  = 8'hFF;
      req0_op = 4'h7;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rr_rsp_valid, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err} !== {1'b1, 8'h08, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL latch: vld=%0b data=%h z=%0b c=%0b e=%0b, required 1 08 0 0 0",
                  rr_rsp_valid, rr_rsp_data, rr_rsp_zero, rr_rsp_carry, rr_rsp_err);
      end
   endtask

   // Transaction-level model per instance (0 = round-robin, 1 = fixed priority):
   // an accepted op occupies the arbiter 3 cycles and its response appears 3 cycles later.
   task automatic test_random(input int ncyc);
      int          free_c [2];
      int          due [2];
      int          last [2];
      logic [10:0] pend [2];
      logic        pend_id [2];
      logic [10:0] hold [2];
      logic        hold_id [2];
      logic        exp_vld, exp_busy, ov, oid, ob, rdy0_o, rdy1_o;
      logic [10:0] od;
      logic        v0, v1;
      logic [7:0]  a0, b0, a1, b1;
      logic [3:0]  o0, o1;
      int          win;
      wait_idle();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         free_c[i] = 0; due[i] = 0; last[i] = 1;
         pend[i] = '0; pend_id[i] = 1'b0; hold[i] = '0; hold_id[i] = 1'b0;
      end
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 2; i++) begin
            exp_vld = (due[i] == 1);
            if (due[i] > 0) due[i]--;
            if (free_c[i] > 0) free_c[i]--;
            exp_busy = (free_c[i] > 0);
            if (exp_vld) begin
               hold[i]    = pend[i];
               hold_id[i] = pend_id[i];
            end
            if (i == 0) begin
               ov = rr_rsp_valid; oid = rr_rsp_id; ob = rr_busy;
               od = {rr_rsp_err, rr_rsp_zero, rr_rsp_carry, rr_rsp_data};
            end else begin
               ov = fp_rsp_valid; oid = fp_rsp_id; ob = fp_busy;
               od = {fp_rsp_err, fp_rsp_zero, fp_rsp_carry, fp_rsp_data};
            end
            checks++;
            if (ov !== exp_vld || oid !== hold_id[i] || od[9:0] !== hold[i][9:0] ||
                (exp_vld && od[10] !== hold[i][10]) || ob !== exp_busy) begin
               errors++;
               $display("FAIL random_rsp inst=%0d cycle=%0d: vld=%0b id=%0b res=%h busy=%0b, required vld=%0b id=%0b res=%h busy=%0b",
                        i, c, ov, oid, od, ob, exp_vld, hold_id[i], hold[i], exp_busy);
            end
         end
         v0 = ($urandom_range(0, 99) < 60);
         v1 = ($urandom_range(0, 99) < 60);
         a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255)); o0 = 4'($urandom_range(0, 15));
         a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); o1 = 4'($urandom_range(0, 15));
         drive(v0, a0, b0, o0, v1, a1, b1, o1);
         #1;
         for (int i = 0; i < 2; i++) begin
            win = -1;
            if (free_c[i] == 0) begin
               if (v0 && v1)  win = (i == 0) ? ((last[i] == 1) ? 0 : 1) : 0;
               else if (v0)   win = 0;
               else if (v1)   win = 1;
            end
            rdy0_o = (i == 0) ? rr_req0_ready : fp_req0_ready;
            rdy1_o = (i == 0) ? rr_req1_ready : fp_req1_ready;
            checks++;
            if (rdy0_o !== (win == 0) || rdy1_o !== (win == 1)) begin
               errors++;
               $display("FAIL random_ready inst=%0d cycle=%0d: ready0=%0b ready1=%0b, required %0b %0b",
                        i, c, rdy0_o, rdy1_o, (win == 0), (win == 1));
            end
            if (win >= 0) begin
               pend[i]    = (win == 0) ? ref_alu(a0, b0, o0) : ref_alu(a1, b1, o1);
               pend_id[i] = (win == 1);
               last[i]    = win;
               free_c[i]  = 3;
               due[i]     = 3;
            end
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
      test_reset();
      test_add();
      test_arbitration();
      test_dec_neg();
      test_illegal();
      test_reset_mid();
      test_latch();
      test_random(600);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
